// File: rtl/tmu_pkg.sv
// ---------------------------------------------------------------------------
// tmu_pkg
//   Shared definitions for the TMU scanline divide stage.
//   - TMU_COORD_W : coordinate / dividend / divisor width
//   - tmu_state_e : divide sequencer states
//   - tmu_pts_t   : pass-through point bundle carried alongside the divide
// ---------------------------------------------------------------------------
package tmu_pkg;

    localparam int TMU_COORD_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } tmu_state_e;

    // Points that ride through the divide untouched.
    typedef struct packed {
        logic [TMU_COORD_W-1:0] y;
        logic [TMU_COORD_W-1:0] s_x;
        logic [TMU_COORD_W-1:0] s_u;
        logic [TMU_COORD_W-1:0] s_v;
        logic [TMU_COORD_W-1:0] e_x;
    } tmu_pts_t;

endpackage

// File: rtl/tmu_divstep_seq.sv
// ---------------------------------------------------------------------------
// tmu_divstep_seq
//   One unsigned restoring divider, one quotient bit per enabled cycle.
//   Ports:
//     clk, rst_n  : clock, async active-low reset (clears quo/rem)
//     load        : load dividend into quotient register, clear remainder
//     step        : perform one restoring step against divisor
//     dividend    : value loaded on load
//     divisor     : divisor, must be held stable while stepping (nonzero)
//     quo, rem    : quotient / remainder registers
//   After WIDTH steps following a load, quo = floor(dividend/divisor) and
//   rem = dividend % divisor.
// ---------------------------------------------------------------------------
module tmu_divstep_seq
    import tmu_pkg::*;
#(
    parameter int WIDTH = TMU_COORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   rem_sub;
    logic             fits;

    // The working remainder is WIDTH+1 bits only after the shift; once the
    // conditional subtract is applied it is always < divisor, so the stored
    // copy never needs its top bit.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        dvs_ext = {1'b0, divisor};
        fits    = (rem_sh >= dvs_ext);
        rem_sub = rem_sh - dvs_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
        end else if (step) begin
            quo_q <= {quo_q[WIDTH-2:0], fits};
            rem_q <= fits ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/tmu_scandiv_seq.sv
// ---------------------------------------------------------------------------
// tmu_scandiv_seq
//   Scanline divide-operands consumer. Accepts one operand set, computes
//   du/divisor and dv/divisor with two parallel restoring dividers (one bit
//   per cycle), then offers the results downstream.
//   Ports:
//     sys_clk, sys_rst_n       : clock, async active-low reset
//     busy                     : high whenever not IDLE
//     pipe_stb_i / pipe_ack_o  : upstream handshake (ack only in IDLE)
//     Y,S_X,S_U,S_V,E_X        : pass-through points
//     du_positive, dv_positive : sign flags, passed through
//     du, dv, divisor          : unsigned dividends and common divisor
//     pipe_stb_o / pipe_ack_i  : downstream handshake (stb only in DONE)
//     *_o                      : registered pass-through values
//     du_q,du_r,dv_q,dv_r      : quotients and remainders
//     divisor_o                : divisor actually used (0 replaced by 1)
//   Latency: accept edge A, steps at A+1..A+WIDTH, valid from A+WIDTH.
//   WIDTH must match TMU_COORD_W since the point bundle uses that width.
// ---------------------------------------------------------------------------
module tmu_scandiv_seq
    import tmu_pkg::*;
#(
    parameter int WIDTH = TMU_COORD_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    output logic             busy,

    input  logic             pipe_stb_i,
    output logic             pipe_ack_o,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] S_X,
    input  logic [WIDTH-1:0] S_U,
    input  logic [WIDTH-1:0] S_V,
    input  logic [WIDTH-1:0] E_X,
    input  logic             du_positive,
    input  logic             dv_positive,
    input  logic [WIDTH-1:0] du,
    input  logic [WIDTH-1:0] dv,
    input  logic [WIDTH-1:0] divisor,

    output logic             pipe_stb_o,
    input  logic             pipe_ack_i,
    output logic [WIDTH-1:0] Y_o,
    output logic [WIDTH-1:0] S_X_o,
    output logic [WIDTH-1:0] S_U_o,
    output logic [WIDTH-1:0] S_V_o,
    output logic [WIDTH-1:0] E_X_o,
    output logic             du_positive_o,
    output logic             dv_positive_o,
    output logic [WIDTH-1:0] du_q,
    output logic [WIDTH-1:0] du_r,
    output logic [WIDTH-1:0] dv_q,
    output logic [WIDTH-1:0] dv_r,
    output logic [WIDTH-1:0] divisor_o
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int               NDIV     = 2;  // [0]=du, [1]=dv

    tmu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    tmu_pts_t         pts_q;
    logic             du_pos_q, dv_pos_q;
    logic [WIDTH-1:0] dvs_q;

    logic             accept;
    logic             step_en;
    logic             last_step;
    logic             out_hs;

    logic [NDIV-1:0][WIDTH-1:0] dvd;
    logic [NDIV-1:0][WIDTH-1:0] quo;
    logic [NDIV-1:0][WIDTH-1:0] rem;

    assign accept    = pipe_stb_i && pipe_ack_o;
    assign step_en   = (state_q == DIV);
    assign last_step = step_en && (cnt_q == '0);
    assign out_hs    = pipe_stb_o && pipe_ack_i;

    // ---- FSM: state register ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = DIV;
            DIV:     if (last_step) state_d = DONE;
            DONE:    if (out_hs)    state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---- FSM: outputs (pure state decode, no path from pipe_ack_i) ----
    always_comb begin
        busy       = (state_q != IDLE);
        pipe_ack_o = (state_q == IDLE);
        pipe_stb_o = (state_q == DONE);
    end

    // Step counter: loaded with WIDTH-1 on accept, counts down in DIV.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)              cnt_q <= '0;
        else if (accept)             cnt_q <= CNT_LAST;
        else if (step_en && !last_step) cnt_q <= cnt_q - 1'b1;
    end

    // Pass-through and divisor capture. A zero divisor is replaced by 1 so
    // the dividers still finish in WIDTH steps with q=dividend, r=0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pts_q    <= '0;
            du_pos_q <= 1'b0;
            dv_pos_q <= 1'b0;
            dvs_q    <= '0;
        end else if (accept) begin
            pts_q    <= '{y: Y, s_x: S_X, s_u: S_U, s_v: S_V, e_x: E_X};
            du_pos_q <= du_positive;
            dv_pos_q <= dv_positive;
            dvs_q    <= (divisor == '0) ? WIDTH'(1) : divisor;
        end
    end

    assign dvd[0] = du;
    assign dvd[1] = dv;

    for (genvar i = 0; i < NDIV; i++) begin : g_div
        tmu_divstep_seq #(
            .WIDTH   (WIDTH)
        ) u_div (
            .clk     (sys_clk),
            .rst_n   (sys_rst_n),
            .load    (accept),
            .step    (step_en),
            .dividend(dvd[i]),
            .divisor (dvs_q),
            .quo     (quo[i]),
            .rem     (rem[i])
        );
    end

    assign Y_o           = pts_q.y;
    assign S_X_o         = pts_q.s_x;
    assign S_U_o         = pts_q.s_u;
    assign S_V_o         = pts_q.s_v;
    assign E_X_o         = pts_q.e_x;
    assign du_positive_o = du_pos_q;
    assign dv_positive_o = dv_pos_q;
    assign du_q          = quo[0];
    assign du_r          = rem[0];
    assign dv_q          = quo[1];
    assign dv_r          = rem[1];
    assign divisor_o     = dvs_q;

endmodule

// File: tb/tb_tmu_scandiv_seq.sv
module tb_tmu_scandiv_seq;

    localparam int W = 11;

    logic         sys_clk, sys_rst_n;
    logic         busy, pipe_stb_i, pipe_ack_o, pipe_stb_o, pipe_ack_i;
    logic [W-1:0] Y, S_X, S_U, S_V, E_X, du, dv, divisor;
    logic         du_positive, dv_positive;
    logic [W-1:0] Y_o, S_X_o, S_U_o, S_V_o, E_X_o;
    logic         du_positive_o, dv_positive_o;
    logic [W-1:0] du_q, du_r, dv_q, dv_r, divisor_o;

    tmu_scandiv_seq #(.WIDTH(W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .busy(busy),
        .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
        .Y(Y), .S_X(S_X), .S_U(S_U), .S_V(S_V), .E_X(E_X),
        .du_positive(du_positive), .dv_positive(dv_positive),
        .du(du), .dv(dv), .divisor(divisor),
        .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
        .Y_o(Y_o), .S_X_o(S_X_o), .S_U_o(S_U_o), .S_V_o(S_V_o), .E_X_o(E_X_o),
        .du_positive_o(du_positive_o), .dv_positive_o(dv_positive_o),
        .du_q(du_q), .du_r(du_r), .dv_q(dv_q), .dv_r(dv_r),
        .divisor_o(divisor_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: floor division with the zero-divisor guard (divisor 0 acts as 1).
    function automatic int eff_div(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    typedef struct {
        int du, dv, dvs;
        logic [W-1:0] y, sx, su, sv, ex;
        bit dp, vp;
    } op_t;

    typedef struct {
        int du, dv, dvs;
        int e_duq, e_dur, e_dvq, e_dvr, e_dvo;
    } vec_t;

    function automatic op_t rand_op();
        op_t o;
        o.du  = $urandom_range(0, 2047);
        o.dv  = $urandom_range(0, 2047);
        o.dvs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 2047);
        o.y = W'($urandom); o.sx = W'($urandom); o.su = W'($urandom);
        o.sv = W'($urandom); o.ex = W'($urandom);
        o.dp = 1'($urandom); o.vp = 1'($urandom);
        return o;
    endfunction

    task automatic apply(input op_t o);
        du = W'(o.du); dv = W'(o.dv); divisor = W'(o.dvs);
        Y = o.y; S_X = o.sx; S_U = o.su; S_V = o.sv; E_X = o.ex;
        du_positive = o.dp; dv_positive = o.vp;
    endtask

    task automatic scramble();
        op_t g;
        g = rand_op();
        apply(g);
    endtask

    // Compare the presented result against the reference for operand set o.
    task automatic chk_result(input string tag, input op_t o);
        int d;
        d = eff_div(o.dvs);
        chk({tag, " du_q"}, int'(du_q), o.du / d);
        chk({tag, " du_r"}, int'(du_r), o.du % d);
        chk({tag, " dv_q"}, int'(dv_q), o.dv / d);
        chk({tag, " dv_r"}, int'(dv_r), o.dv % d);
        chk({tag, " divisor_o"}, int'(divisor_o), d);
        chk({tag, " pts"}, int'({Y_o, S_X_o, S_U_o, S_V_o, E_X_o} == {o.y, o.sx, o.su, o.sv, o.ex}), 1);
        chk({tag, " signs"}, int'({du_positive_o, dv_positive_o}), int'({o.dp, o.vp}));
    endtask

    // Runs one operation from IDLE: accept, count latency, check busy.
    // Leaves the bench at #1 after the edge where pipe_stb_o rose.
    task automatic run_to_done(input string tag, input op_t o);
        int n;
        apply(o);
        pipe_stb_i = 1'b1;
        chk({tag, " ack_o idle"}, int'(pipe_ack_o), 1);
        @(posedge sys_clk); #1;
        pipe_stb_i = 1'b0;
        scramble();
        n = 0;
        while (!pipe_stb_o && n < 40) begin
            chk({tag, " busy div"}, int'(busy), 1);
            @(posedge sys_clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, W);
        chk({tag, " busy done"}, int'(busy), 1);
        chk({tag, " ack_o done"}, int'(pipe_ack_o), 0);
    endtask

    task automatic finish_hs(input string tag);
        pipe_ack_i = 1'b1;
        @(posedge sys_clk); #1;
        chk({tag, " stb_o after hs"}, int'(pipe_stb_o), 0);
        chk({tag, " busy after hs"}, int'(busy), 0);
        chk({tag, " ack_o after hs"}, int'(pipe_ack_o), 1);
    endtask

    function automatic logic [10*W+1:0] snap();
        return {Y_o, S_X_o, S_U_o, S_V_o, E_X_o, du_positive_o, dv_positive_o,
                du_q, du_r, dv_q, dv_r, divisor_o};
    endfunction

    vec_t tbl[6];
    op_t  q[$];

    initial begin
        op_t o, cur, e;
        logic [10*W+1:0] s0;
        int got, cyc, acc_cnt, last_acc;
        bit acc, hs;

        tbl[0] = '{100,  5,    7,    14,   2, 0, 5, 7};
        tbl[1] = '{2047, 0,    1,    2047, 0, 0, 0, 1};
        tbl[2] = '{1,    2046, 2047, 0,    1, 0, 2046, 2047};
        tbl[3] = '{37,   11,   0,    37,   0, 11, 0, 1};
        tbl[4] = '{2047, 2047, 2047, 1,    0, 1, 0, 2047};
        tbl[5] = '{1000, 999,  3,    333,  1, 333, 0, 3};

        sys_rst_n = 1'b0; pipe_stb_i = 1'b0; pipe_ack_i = 1'b1;
        scramble();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst stb_o", int'(pipe_stb_o), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst ack_o", int'(pipe_ack_o), 1);
        chk("rst outs zero", int'(snap() == '0), 1);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Table-driven directed vectors, downstream always ready.
        for (int i = 0; i < 6; i++) begin
            o = rand_op();
            o.du = tbl[i].du; o.dv = tbl[i].dv; o.dvs = tbl[i].dvs;
            run_to_done($sformatf("vec%0d", i), o);
            chk($sformatf("vec%0d du_q", i), int'(du_q), tbl[i].e_duq);
            chk($sformatf("vec%0d du_r", i), int'(du_r), tbl[i].e_dur);
            chk($sformatf("vec%0d dv_q", i), int'(dv_q), tbl[i].e_dvq);
            chk($sformatf("vec%0d dv_r", i), int'(dv_r), tbl[i].e_dvr);
            chk($sformatf("vec%0d divisor_o", i), int'(divisor_o), tbl[i].e_dvo);
            chk_result($sformatf("vec%0d", i), o);
            finish_hs($sformatf("vec%0d", i));
        end

        // Backpressure: hold in DONE, upstream toggling with new data.
        pipe_ack_i = 1'b0;
        o = rand_op(); o.du = 500; o.dv = 123; o.dvs = 9;
        run_to_done("bp", o);
        s0 = snap();
        for (int i = 0; i < 5; i++) begin
            pipe_stb_i = ~pipe_stb_i;
            scramble();
            @(posedge sys_clk); #1;
            chk("bp stb_o held", int'(pipe_stb_o), 1);
            chk("bp ack_o low", int'(pipe_ack_o), 0);
            chk("bp outs stable", int'(snap() == s0), 1);
        end
        pipe_stb_i = 1'b0;
        chk_result("bp", o);
        finish_hs("bp");
        o = rand_op(); o.du = 77; o.dv = 1234; o.dvs = 10;
        run_to_done("post bp", o);
        chk_result("post bp", o);
        finish_hs("post bp");

        // Asynchronous reset in the middle of the divide.
        o = rand_op(); o.du = 1500; o.dv = 700; o.dvs = 13;
        apply(o);
        pipe_stb_i = 1'b1;
        @(posedge sys_clk); #1;
        pipe_stb_i = 1'b0;
        repeat (6) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst ack_o", int'(pipe_ack_o), 1);
        chk("midrst stb_o", int'(pipe_stb_o), 0);
        chk("midrst outs zero", int'(snap() == '0), 1);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        chk("after rst stb_o", int'(pipe_stb_o), 0);
        run_to_done("after rst", o);
        chk_result("after rst", o);
        finish_hs("after rst");

        // Back-to-back random sets, random downstream ack, in-order scoreboard.
        got = 0; cyc = 0; acc_cnt = 0; last_acc = 0;
        cur = rand_op();
        apply(cur);
        pipe_stb_i = 1'b1;
        while (got < 20 && cyc < 3000) begin
            pipe_ack_i = 1'($urandom_range(0, 1));
            #1;
            acc = pipe_stb_i && pipe_ack_o;
            hs  = pipe_stb_o && pipe_ack_i;
            if (hs) begin
                if (q.size() == 0) chk("rnd spurious result", 1, 0);
                else begin
                    e = q.pop_front();
                    chk_result($sformatf("rnd%0d", got), e);
                end
                got++;
            end
            if (acc) begin
                q.push_back(cur);
                if (acc_cnt > 0) chk("rnd accept spacing", int'(cyc - last_acc >= W + 2), 1);
                last_acc = cyc;
                acc_cnt++;
            end
            @(posedge sys_clk); #1;
            cyc++;
            if (acc) begin
                if (acc_cnt < 20) begin
                    cur = rand_op();
                    apply(cur);
                end else begin
                    pipe_stb_i = 1'b0;
                end
            end
        end
        chk("rnd results", got, 20);
        chk("rnd queue empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
